// File: rtl/maze_pkg.sv
// Shared constants and types for the maze RAM arbiter slice.
package maze_pkg;

   localparam int unsigned MAZE_ADDR_W = 16;
   localparam logic [MAZE_ADDR_W-1:0] ADDR_NONE  = 16'hFFFF;
   localparam logic [MAZE_ADDR_W-1:0] MAZE_WORDS = 16'd63360; // 240 x 264
   localparam logic [7:0] BLK = 8'h00;

   typedef enum logic [1:0] {IDLE, DISP, DRAIN} arb_state_t;

   typedef struct packed {
      logic [MAZE_ADDR_W-1:0] addr;
      logic [7:0]             data;
   } wr_entry_t;

   function automatic logic addr_in_maze(input logic [MAZE_ADDR_W-1:0] a,
                                         input logic [MAZE_ADDR_W-1:0] none);
      return (a != none) && (a < MAZE_WORDS);
   endfunction

endpackage

// File: rtl/maze_wr_fifo.sv
// Synchronous queue of {addr,data} tile writes waiting for a RAM write window.
module maze_wr_fifo
   import maze_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wr_entry_t              push_entry,
   input  logic                   pop,
   output wr_entry_t              head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

   wr_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_push = push && (count != FULL);
      do_pop  = pop && (count != '0);
   end

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/maze_ram_arbiter.sv
// Maze RAM arbiter: the pixel pipeline owns the RAM in the visible area, queued tile writes drain
// in blanking. Define MAZE_ARB_HBLANK_WR_EN to also drain writes during horizontal blanking.
module maze_ram_arbiter
   import maze_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] ADDR_NONE  = maze_pkg::ADDR_NONE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         disp_active,
   input  logic                         vblank,
   input  logic [15:0]                  disp_addr,
   output logic [7:0]                   disp_data,
   input  logic                         upd_valid,
   output logic                         upd_ready,
   input  logic [15:0]                  upd_addr,
   input  logic [7:0]                   upd_data,
   output logic [15:0]                  ram_addr,
   output logic [7:0]                   ram_wdata,
   output logic                         ram_we,
   input  logic [7:0]                   ram_rdata,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         wr_done
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   arb_state_t state;
   arb_state_t grant;
   wr_entry_t  head;
   wr_entry_t  push_entry;
   logic       window;
   logic       push;
   logic       disp_ok_q;

`ifdef MAZE_ARB_HBLANK_WR_EN
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign window        = !disp_active;
`else
   assign window = vblank;
`endif

   // Ownership is decided from this cycle's inputs so the display wins without a cycle of lag.
   always_comb begin
      grant = IDLE;
      if (!rst) begin
         grant = IDLE;
      end else if (disp_active) begin
         grant = DISP;
      end else if (window && (fifo_count != '0)) begin
         grant = DRAIN;
      end
   end

   assign upd_ready  = rst && (fifo_count < DEPTH_C);
   assign push       = upd_valid && upd_ready && addr_in_maze(upd_addr, ADDR_NONE);
   assign push_entry = '{addr: upd_addr, data: upd_data};

   assign ram_we    = (grant == DRAIN);
   assign ram_addr  = ram_we ? head.addr : disp_addr;
   assign ram_wdata = head.data;
   assign disp_data = ((state == DISP) && disp_ok_q) ? ram_rdata : BLK;

   maze_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (ram_we),
      .head       (head),
      .count      (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         disp_ok_q <= 1'b0;
         wr_done   <= 1'b0;
      end else begin
         state     <= grant;
         disp_ok_q <= disp_active && (disp_addr != ADDR_NONE);
         wr_done   <= (grant == DRAIN);
      end
   end

endmodule

// File: doc/maze_ram_arbiter.md
MAZE_RAM_ARBITER -- requirements
Module: maze_ram_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, update-write queue depth, power of two, 2..16.
REQ-002 Parameter: ADDR_NONE, 16'hFFFF, "no maze pixel" sentinel address.
REQ-003 Port: clk  in  1  sole clock, all state on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-low reset.
REQ-005 Port: disp_active  in  1  pixel inside the 640x480 visible area this cycle.
REQ-006 Port: vblank  in  1  vertical blanking interval (vc >= 480).
REQ-007 Port: disp_addr  in  16  maze RAM address requested by the pixel pipeline.
REQ-008 Port: disp_data  out  8  maze colour for disp_addr, one cycle later.
REQ-009 Port: upd_valid / upd_ready  in/out  1/1  game-logic tile-write handshake.
REQ-010 Port: upd_addr, upd_data  in  16, 8  write address and colour.
REQ-011 Port: ram_addr, ram_wdata, ram_we  out  16, 8, 1  single-port synchronous RAM, read latency 1.
REQ-012 Port: ram_rdata  in  8  RAM read data.
REQ-013 Port: fifo_count  out  clog2(FIFO_DEPTH)+1  queued writes; wr_done  out  1  one-cycle pulse per committed write.

Function
REQ-014 FSM states: DISP (display owns RAM), DRAIN (one queued write issued per cycle), IDLE (no owner).
REQ-015 Any state -> DISP when disp_active=1; display wins the same cycle, with no write issued that cycle.
REQ-016 Write window = vblank (macro off), or disp_active=0 (macro on). In window with fifo_count>0 -> DRAIN; otherwise IDLE.
REQ-017 DRAIN with fifo_count=0 -> IDLE; DRAIN with the window closed -> DISP or IDLE; the head entry is not popped.
REQ-018 In DISP: ram_addr=disp_addr, ram_we=0. In DRAIN: ram_addr/ram_wdata = FIFO head, ram_we=1, pop that cycle, wr_done=1 next cycle.
REQ-019 disp_data at cycle N+1 = ram_rdata for disp_addr of cycle N, if disp_active=1 and disp_addr!=ADDR_NONE at N; else 8'h00.
REQ-020 Accepted upd writes to ADDR_NONE or to addr >= 63360 are consumed and dropped: no ram_we, no wr_done.
REQ-021 upd_ready = (fifo_count < FIFO_DEPTH); accept on upd_valid&upd_ready; full FIFO -> upd_ready=0, upstream holds its data.
REQ-022 Simultaneous push and pop: count unchanged, order preserved; a push into an empty FIFO is writable at the earliest next cycle.
REQ-023 Writes commit in strict acceptance order; no write is ever lost except on reset.
REQ-024 ram_we=0 whenever disp_active=1; RAM read contents are never altered by the arbiter in the visible area.

Reset
REQ-025 rst=0 at an edge: state=IDLE, FIFO emptied, fifo_count=0, disp_data=0, wr_done=0, ram_we=0, upd_ready=0 during reset.
REQ-026 Reset mid-DRAIN discards queued writes; a write already issued (ram_we was high) stays committed in RAM.

Configuration
REQ-027 Macro MAZE_ARB_HBLANK_WR_EN: defined -> writes drain during any cycle with disp_active=0 (h-blank and v-blank); undefined -> writes drain only while vblank=1.

Structure
REQ-028 Package maze_pkg: MAZE_ADDR_W=16, ADDR_NONE, MAZE_WORDS=63360 (240x264), colour BLK=8'h00, state enum arb_state_t {IDLE, DISP, DRAIN}.
REQ-029 One sub-module, maze_wr_fifo: synchronous FIFO of {addr,data} with push/pop/count; arbiter holds the FSM and muxing only.

Verification
REQ-030 Visible area, disp_addr=100 with RAM[100]=8'h03 -> disp_data=8'h03 one cycle later; disp_addr=16'hFFFF -> disp_data=8'h00.
REQ-031 Push 5 writes while disp_active=1, FIFO_DEPTH=4 -> 4 accepted, upd_ready=0; no ram_we until vblank; then 4 consecutive ram_we cycles in order, 4 wr_done pulses.
REQ-032 Push and pop in the same DRAIN cycle at count=2 -> count stays 2, RAM order matches acceptance order.
REQ-033 disp_active rises during DRAIN with 3 queued -> ram_we=0 that cycle, count stays 3, drain resumes at the next window.
REQ-034 Macro undefined: h-blank with vblank=0 -> no writes; macro defined: same stimulus -> writes drain in h-blank.
REQ-035 rst=0 with 3 queued mid-DRAIN -> after reset count=0, no further ram_we, disp_data=0.
